// File: rtl/tank_pkg.sv
// tank_pkg: shared tank constants, field limits and the fire-control state enum.
package tank_pkg;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam int FIELD_X_MAX = 24;
  localparam int FIELD_Y_MAX = 12;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_FLY,
    ST_RELEASE,
    ST_COOLDOWN
  } shoot_st_t;
endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: 2-FF synchroniser for an asynchronous key plus a rising-edge pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic key_lvl_o,
  output logic key_rise_o
);
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= key_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign key_lvl_o  = s2_q;
  assign key_rise_o = s2_q & ~prev_q;
endmodule

// File: rtl/tank_shoot_ctrl.sv
// tank_shoot_ctrl: per-tank fire control driving the bullet handshake, with cooldown.
// Define SHOOT_AUTOFIRE_EN to let a held key refire every cooldown period.
module tank_shoot_ctrl
  import tank_pkg::*;
#(
  parameter int COOLDOWN_TICKS = 4,
  parameter int ARM_TIMEOUT    = 3,
  parameter int X_MAX          = FIELD_X_MAX,
  parameter int Y_MAX          = FIELD_Y_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       tick_8hz,
  input  logic       fire_key,
  input  logic [1:0] tank_dir,
  input  logic [4:0] tank_xpos,
  input  logic [4:0] tank_ypos,
  input  logic       bul_state_feedback,
  output logic       bul_state,
  output logic [1:0] bul_dir,
  output logic [4:0] bul_x_init,
  output logic [4:0] bul_y_init,
  output logic       busy,
  output logic [7:0] shot_cnt
);
`ifdef SHOOT_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif
  shoot_st_t  st_q, st_d;
  logic       pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d, tmr_q, tmr_d;
  logic [1:0] dir_q, dir_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  logic       key_lvl, key_rise, tick, pend_eff, oob;

  key_sync_edge u_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_i     (fire_key),
    .key_lvl_o (key_lvl),
    .key_rise_o(key_rise)
  );

  assign tick     = tick_8hz & enable;
  assign pend_eff = pend_q | (AUTOFIRE & key_lvl);
  assign oob      = (32'(tank_xpos) > X_MAX) || (32'(tank_ypos) > Y_MAX);

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    tmr_d  = tmr_q;
    dir_d  = dir_q;
    x_d    = x_q;
    y_d    = y_q;
    if (enable) begin
      pend_d = 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          pend_d = pend_q | key_rise;
          if (tick && pend_eff) begin
            // launch position is captured on entry so it is valid throughout LOAD
            if (oob) pend_d = key_rise;
            else begin
              st_d  = ST_LOAD;
              dir_d = tank_dir;
              x_d   = tank_xpos;
              y_d   = tank_ypos;
            end
          end
        end
        ST_LOAD: begin
          st_d  = ST_ARM;
          tmr_d = '0;
        end
        ST_ARM: if (tick) begin
          if (bul_state_feedback) begin
            st_d  = ST_FLY;
            cnt_d = cnt_q + 8'd1;
          end else if (tmr_q == 8'(ARM_TIMEOUT - 1)) st_d = ST_RELEASE;
          else tmr_d = tmr_q + 8'd1;
        end
        ST_FLY: if (tick && !bul_state_feedback) st_d = ST_RELEASE;
        ST_RELEASE: if (tick) begin
          tmr_d = '0;
          st_d  = (COOLDOWN_TICKS == 0) ? ST_IDLE : ST_COOLDOWN;
        end
        ST_COOLDOWN: if (tick) begin
          st_d  = (tmr_q == 8'(COOLDOWN_TICKS - 1)) ? ST_IDLE : ST_COOLDOWN;
          tmr_d = tmr_q + 8'd1;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      tmr_q  <= '0;
      dir_q  <= DIR_UP;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      dir_q  <= dir_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign bul_state  = (st_q == ST_ARM) || (st_q == ST_FLY);
  assign busy       = st_q != ST_IDLE;
  assign bul_dir    = dir_q;
  assign bul_x_init = x_q;
  assign bul_y_init = y_q;
  assign shot_cnt   = cnt_q;
endmodule
